// File: rtl/mult_ctrl_pkg.sv
// Shared definitions for the shift-add multiplier controller:
// the FSM state encoding and the iteration-counter width derivation.
package mult_ctrl_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_TEST  = 3'd2;
  localparam logic [2:0] ST_ADD   = 3'd3;
  localparam logic [2:0] ST_SHIFT = 3'd4;
  localparam logic [2:0] ST_FIN   = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_LOAD  = ST_LOAD,
    S_TEST  = ST_TEST,
    S_ADD   = ST_ADD,
    S_SHIFT = ST_SHIFT,
    S_FIN   = ST_FIN
  } state_t;

  // Counter must hold the value WIDTH itself, hence WIDTH+1 codes.
  function automatic int cnt_w_for(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shift_add_mult_ctrl_iter_counter.sv
// Loadable iteration down-counter; LAST flags the final remaining iteration.
module iter_counter #(
  parameter int CNT_W = 3
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             LD,
  input  logic [CNT_W-1:0] LD_VAL,
  input  logic             DEC,
  output logic [CNT_W-1:0] CNT,
  output logic             LAST
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic [CNT_W-1:0] cnt_r;

  // Load has priority; decrement saturates at zero so the count never wraps.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_r <= CNT_ZERO;
    end else if (LD) begin
      cnt_r <= LD_VAL;
    end else if (DEC && (cnt_r != CNT_ZERO)) begin
      cnt_r <= cnt_r - CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign CNT  = cnt_r;
  assign LAST = (cnt_r == CNT_ONE);

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Moore FSM sequencing an external WIDTH-bit shift-add multiplier datapath:
// LOAD, then per multiplier bit an optional ADD followed by a SHIFT, then a DONE pulse.
module shift_add_mult_ctrl
  import mult_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = cnt_w_for(WIDTH)
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             START,
  input  logic             ABORT,
  input  logic             Q0,
  output logic             LOAD,
  output logic             ADD_EN,
  output logic             SHIFT_EN,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] COUNT
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  state_t           state_r;
  state_t           state_nxt_s;
  logic             cnt_ld_s;
  logic [CNT_W-1:0] cnt_ld_val_s;
  logic             cnt_dec_s;
  logic [CNT_W-1:0] cnt_s;
  logic             cnt_last_s;

  iter_counter #(
    .CNT_W (CNT_W)
  ) u_iter_counter (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .LD      (cnt_ld_s),
    .LD_VAL  (cnt_ld_val_s),
    .DEC     (cnt_dec_s),
    .CNT     (cnt_s),
    .LAST    (cnt_last_s)
  );

  // State register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and counter control; ABORT outside IDLE overrides everything.
  always_comb begin
    state_nxt_s  = state_r;
    cnt_ld_s     = 1'b0;
    cnt_ld_val_s = CNT_ZERO;
    cnt_dec_s    = 1'b0;
    if (ABORT && (state_r != S_IDLE)) begin
      state_nxt_s  = S_IDLE;
      cnt_ld_s     = 1'b1;
      cnt_ld_val_s = CNT_ZERO;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (START) begin
            state_nxt_s = S_LOAD;
          end else begin
            state_nxt_s = S_IDLE;
          end
        end
        S_LOAD: begin
          cnt_ld_s     = 1'b1;
          cnt_ld_val_s = CNT_INIT;
          state_nxt_s  = S_TEST;
        end
        S_TEST: begin
          if (Q0) begin
            state_nxt_s = S_ADD;
          end else begin
            state_nxt_s = S_SHIFT;
          end
        end
        S_ADD: begin
          state_nxt_s = S_SHIFT;
        end
        S_SHIFT: begin
          cnt_dec_s = 1'b1;
          if (cnt_last_s) begin
            state_nxt_s = S_FIN;
          end else begin
            state_nxt_s = S_TEST;
          end
        end
        S_FIN: begin
          state_nxt_s = S_IDLE;
        end
        default: begin
          state_nxt_s  = S_IDLE;
          cnt_ld_s     = 1'b1;
          cnt_ld_val_s = CNT_ZERO;
        end
      endcase
    end
  end

  // Outputs decode only registered state and counter.
  assign LOAD     = (state_r == S_LOAD);
  assign ADD_EN   = (state_r == S_ADD);
  assign SHIFT_EN = (state_r == S_SHIFT);
  assign BUSY     = (state_r != S_IDLE);
  assign DONE     = (state_r == S_FIN);
  assign COUNT    = cnt_s;

endmodule
